// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory-port arbiter: FSM states and transaction op.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_ISSUE   = 2'd1,
    ARB_WAIT_DN = 2'd2,
    ARB_RESP    = 2'd3
  } arb_state_t;

  typedef enum logic {
    ARB_OP_READ  = 1'b0,
    ARB_OP_WRITE = 1'b1
  } arb_op_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester-side and controller-side signals of the arbiter; master is the arbiter's view,
// slave is the view of whatever surrounds it (requesters plus memory controller).
interface mem_port_arbiter_if #(
  parameter int CPU_QUANTITY = 2,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32
);
  localparam int IDX_W = (CPU_QUANTITY > 1) ? $clog2(CPU_QUANTITY) : 1;

  logic [CPU_QUANTITY-1:0]        req_read_q;
  logic [CPU_QUANTITY-1:0]        req_write_q;
  logic [CPU_QUANTITY*ADDR_W-1:0] req_addr;
  logic [CPU_QUANTITY*DATA_W-1:0] req_wdata;
  logic [CPU_QUANTITY-1:0]        req_read_dn;
  logic [CPU_QUANTITY-1:0]        req_write_dn;
  logic [DATA_W-1:0]              req_rdata;
  logic [IDX_W-1:0]               grant_idx;
  logic                           busy;
  logic                           mem_read_q;
  logic                           mem_write_q;
  logic [ADDR_W-1:0]              mem_addr;
  logic [DATA_W-1:0]              mem_wdata;
  logic [DATA_W-1:0]              mem_rdata;
  logic                           mem_read_dn;
  logic                           mem_write_dn;
  logic                           err;

  modport master (
    input  req_read_q, req_write_q, req_addr, req_wdata,
    input  mem_rdata, mem_read_dn, mem_write_dn,
    output req_read_dn, req_write_dn, req_rdata, grant_idx, busy,
    output mem_read_q, mem_write_q, mem_addr, mem_wdata, err
  );

  modport slave (
    output req_read_q, req_write_q, req_addr, req_wdata,
    output mem_rdata, mem_read_dn, mem_write_dn,
    input  req_read_dn, req_write_dn, req_rdata, grant_idx, busy,
    input  mem_read_q, mem_write_q, mem_addr, mem_wdata, err
  );

endinterface

// File: rtl/mem_port_arbiter_rr_pick.sv
// Combinational rotate-priority encoder: first set bit of req strictly after last, wrapping.
// Zero latency; no state, so it is also usable for other round-robin loops.
module mem_port_arbiter_rr_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          found,
  output logic [IW-1:0] idx
);

  function automatic logic [IW-1:0] wrap(input logic [IW-1:0] base, input int off);
    return IW'((int'(base) + off) % N);
  endfunction

  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int off = 1; off <= N; off++) begin
      if (!found && req[wrap(last, off)]) begin
        found = 1'b1;
        idx   = wrap(last, off);
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter serialising CPU_QUANTITY requesters onto one memory controller port.
// Optional watchdog on the controller handshake is built when MEM_ARB_TIMEOUT_EN is defined.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int CPU_QUANTITY   = 2,
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic               CLK,
  input logic               RESET,
  mem_port_arbiter_if.master bus
);

  localparam int IDX_W = (CPU_QUANTITY > 1) ? $clog2(CPU_QUANTITY) : 1;

  arb_state_t        state;
  arb_state_t        state_nxt;
  arb_op_t           op_q;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  last_grant;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_found;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              done_match;
  logic              timeout;

  mem_port_arbiter_rr_pick #(.N(CPU_QUANTITY), .IW(IDX_W)) u_rr_pick (
    .req   (bus.req_read_q | bus.req_write_q),
    .last  (last_grant),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // A done for the other op type is never accepted as completion.
  assign done_match = (op_q == ARB_OP_READ) ? bus.mem_read_dn : bus.mem_write_dn;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wd_cnt;
  logic             err_q;

  assign timeout = (state == ARB_WAIT_DN) && !done_match &&
                   (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wd_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      err_q  <= timeout;
      wd_cnt <= (state == ARB_WAIT_DN) ? wd_cnt + CNT_W'(1) : '0;
    end
  end

  assign bus.err = err_q;
`else
  // Watchdog compiled out: WAIT_DN waits forever and err is constant 0.
  localparam bit ERR_TIE = 1'b0 && (TIMEOUT_CYCLES > 0);

  assign timeout = 1'b0;
  assign bus.err = ERR_TIE;
`endif

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= ARB_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ARB_IDLE:    if (pick_found) state_nxt = ARB_ISSUE;
      ARB_ISSUE:   state_nxt = ARB_WAIT_DN;
      ARB_WAIT_DN: begin
        if (done_match)   state_nxt = ARB_RESP;
        else if (timeout) state_nxt = ARB_IDLE;
      end
      ARB_RESP:    state_nxt = ARB_IDLE;
      default:     state_nxt = ARB_IDLE;
    endcase
  end

  // Transaction context: latched at grant, read data captured on completion.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      idx_q      <= '0;
      op_q       <= ARB_OP_READ;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      last_grant <= IDX_W'(CPU_QUANTITY - 1);
    end else begin
      if (state == ARB_IDLE && pick_found) begin
        idx_q   <= pick_idx;
        op_q    <= bus.req_write_q[pick_idx] ? ARB_OP_WRITE : ARB_OP_READ;
        addr_q  <= bus.req_addr[pick_idx*ADDR_W +: ADDR_W];
        wdata_q <= bus.req_wdata[pick_idx*DATA_W +: DATA_W];
      end
      if (state == ARB_WAIT_DN && done_match && op_q == ARB_OP_READ)
        rdata_q <= bus.mem_rdata;
      if (state == ARB_RESP || timeout)
        last_grant <= idx_q;
    end
  end

  always_comb begin
    bus.req_read_dn  = '0;
    bus.req_write_dn = '0;
    bus.mem_read_q   = 1'b0;
    bus.mem_write_q  = 1'b0;
    bus.busy         = (state != ARB_IDLE);
    case (state)
      ARB_ISSUE: begin
        bus.mem_read_q  = (op_q == ARB_OP_READ);
        bus.mem_write_q = (op_q == ARB_OP_WRITE);
      end
      ARB_RESP: begin
        if (op_q == ARB_OP_READ) bus.req_read_dn[idx_q]  = 1'b1;
        else                     bus.req_write_dn[idx_q] = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.grant_idx = idx_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.req_rdata = rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: the bench plays both requesters and the memory controller.
module tb_mem_port_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;
  logic [31:0] mem_word;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.CPU_QUANTITY(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_port_arbiter #(
    .CPU_QUANTITY(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input bit rd, input bit wr,
                         input logic [31:0] a, input logic [31:0] d);
    bus.req_read_q[i]          = rd;
    bus.req_write_q[i]         = wr;
    bus.req_addr[i*AW +: AW]   = a;
    bus.req_wdata[i*DW +: DW]  = d;
  endtask

  task automatic clear_reqs();
    bus.req_read_q  = '0;
    bus.req_write_q = '0;
    bus.req_addr    = '0;
    bus.req_wdata   = '0;
  endtask

  task automatic wait_strobe(output bit ok, output int cyc);
    ok  = 1'b0;
    cyc = 0;
    for (int n = 0; n < 16; n++) begin
      if (bus.mem_read_q || bus.mem_write_q) begin
        ok = 1'b1;
        break;
      end
      step();
      cyc++;
    end
  endtask

  // Controller completes the transaction now sitting in WAIT_DN; returns in the RESP cycle.
  task automatic finish_txn(input bit rd, input logic [31:0] d);
    if (rd) begin
      bus.mem_read_dn = 1'b1;
      bus.mem_rdata   = d;
    end else begin
      bus.mem_write_dn = 1'b1;
    end
    step();
    bus.mem_read_dn  = 1'b0;
    bus.mem_write_dn = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_reqs();
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    clear_reqs();
    step();
    step();
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", bus.busy); end
    checks++; if ({bus.mem_read_q, bus.mem_write_q} !== 2'b00) begin failures++; $display("FAIL reset_strobes got=%b want=00", {bus.mem_read_q, bus.mem_write_q}); end
    checks++; if (bus.grant_idx !== 1'b0) begin failures++; $display("FAIL reset_grant got=%0d want=0", bus.grant_idx); end
    checks++; if ({bus.req_read_dn, bus.req_write_dn} !== 4'b0000) begin failures++; $display("FAIL reset_dn got=%b want=0000", {bus.req_read_dn, bus.req_write_dn}); end
    checks++; if (bus.mem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h want=0", bus.mem_addr); end
    checks++; if (bus.req_rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h want=0", bus.req_rdata); end
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", bus.err); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_single_read();
    bit ok;
    int cyc;
    set_req(1, 1'b1, 1'b0, 32'h10, 32'h0);
    wait_strobe(ok, cyc);
    checks++; if (ok !== 1'b1) begin failures++; $display("FAIL single_strobe_seen got=%b want=1", ok); end
    checks++; if (cyc !== 1) begin failures++; $display("FAIL single_issue_latency got=%0d want=1", cyc); end
    checks++; if ({bus.mem_read_q, bus.mem_write_q} !== 2'b10) begin failures++; $display("FAIL single_strobes got=%b want=10", {bus.mem_read_q, bus.mem_write_q}); end
    checks++; if (bus.mem_addr !== 32'h10) begin failures++; $display("FAIL single_addr got=%h want=10", bus.mem_addr); end
    checks++; if (bus.grant_idx !== 1'b1) begin failures++; $display("FAIL single_grant got=%0d want=1", bus.grant_idx); end
    step();
    checks++; if (bus.mem_read_q !== 1'b0) begin failures++; $display("FAIL single_strobe_one_cycle got=%b want=0", bus.mem_read_q); end
    checks++; if (bus.mem_addr !== 32'h10) begin failures++; $display("FAIL single_addr_held got=%h want=10", bus.mem_addr); end
    finish_txn(1'b1, 32'hDEADBEEF);
    checks++; if (bus.req_read_dn !== 2'b10) begin failures++; $display("FAIL single_read_dn got=%b want=10", bus.req_read_dn); end
    checks++; if (bus.req_rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL single_rdata got=%h want=deadbeef", bus.req_rdata); end
    checks++; if (bus.req_write_dn !== 2'b00) begin failures++; $display("FAIL single_write_dn got=%b want=00", bus.req_write_dn); end
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
    step();
    checks++; if ({bus.req_read_dn, bus.busy} !== 3'b000) begin failures++; $display("FAIL single_idle got=%b want=000", {bus.req_read_dn, bus.busy}); end
  endtask

  task automatic test_alternation();
    bit ok;
    int cyc;
    logic exp_idx;
    logic [1:0] exp_dn;
    logic [31:0] exp_addr;
    logic [31:0] exp_data;
    do_reset();
    set_req(0, 1'b1, 1'b0, 32'h100, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'h104, 32'h0);
    for (int t = 0; t < 6; t++) begin
      exp_idx  = (t % 2 == 1);
      exp_dn   = exp_idx ? 2'b10 : 2'b01;
      exp_addr = exp_idx ? 32'h104 : 32'h100;
      exp_data = 32'hA000_0000 + 32'(t);
      wait_strobe(ok, cyc);
      checks++; if (ok !== 1'b1) begin failures++; $display("FAIL alt_strobe_seen t=%0d got=%b want=1", t, ok); end
      checks++; if (bus.grant_idx !== exp_idx) begin failures++; $display("FAIL alt_grant t=%0d got=%0d want=%0d", t, bus.grant_idx, exp_idx); end
      checks++; if (bus.mem_addr !== exp_addr) begin failures++; $display("FAIL alt_addr t=%0d got=%h want=%h", t, bus.mem_addr, exp_addr); end
      step();
      finish_txn(1'b1, exp_data);
      checks++; if (bus.req_read_dn !== exp_dn) begin failures++; $display("FAIL alt_dn t=%0d got=%b want=%b", t, bus.req_read_dn, exp_dn); end
      checks++; if (bus.req_rdata !== exp_data) begin failures++; $display("FAIL alt_rdata t=%0d got=%h want=%h", t, bus.req_rdata, exp_data); end
      step();
    end
    clear_reqs();
    step();
  endtask

  task automatic test_rw_same();
    bit ok;
    int cyc;
    set_req(0, 1'b1, 1'b1, 32'h20, 32'h5);
    wait_strobe(ok, cyc);
    checks++; if ({bus.mem_read_q, bus.mem_write_q} !== 2'b01) begin failures++; $display("FAIL rw_write_first got=%b want=01", {bus.mem_read_q, bus.mem_write_q}); end
    checks++; if (bus.mem_wdata !== 32'h5) begin failures++; $display("FAIL rw_wdata got=%h want=5", bus.mem_wdata); end
    checks++; if (bus.mem_addr !== 32'h20) begin failures++; $display("FAIL rw_waddr got=%h want=20", bus.mem_addr); end
    mem_word = bus.mem_wdata;
    step();
    finish_txn(1'b0, 32'h0);
    checks++; if ({bus.req_write_dn, bus.req_read_dn} !== 4'b0100) begin failures++; $display("FAIL rw_write_dn got=%b want=0100", {bus.req_write_dn, bus.req_read_dn}); end
    set_req(0, 1'b1, 1'b0, 32'h20, 32'h5);
    step();
    wait_strobe(ok, cyc);
    checks++; if ({bus.mem_read_q, bus.mem_write_q} !== 2'b10) begin failures++; $display("FAIL rw_read_second got=%b want=10", {bus.mem_read_q, bus.mem_write_q}); end
    step();
    finish_txn(1'b1, mem_word);
    checks++; if (bus.req_read_dn !== 2'b01) begin failures++; $display("FAIL rw_read_dn got=%b want=01", bus.req_read_dn); end
    checks++; if (bus.req_rdata !== 32'h5) begin failures++; $display("FAIL rw_rdata got=%h want=5", bus.req_rdata); end
    clear_reqs();
    step();
  endtask

  task automatic test_stray_done();
    bit ok;
    int cyc;
    set_req(1, 1'b1, 1'b0, 32'h30, 32'h0);
    wait_strobe(ok, cyc);
    step();
    bus.mem_write_dn = 1'b1;
    step();
    bus.mem_write_dn = 1'b0;
    checks++; if ({bus.busy, bus.req_read_dn, bus.req_write_dn} !== 5'b10000) begin failures++; $display("FAIL stray_ignored got=%b want=10000", {bus.busy, bus.req_read_dn, bus.req_write_dn}); end
    step();
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL stray_still_waiting got=%b want=1", bus.busy); end
    finish_txn(1'b1, 32'h1234);
    checks++; if ({bus.req_read_dn, bus.req_write_dn} !== 4'b1000) begin failures++; $display("FAIL stray_read_dn got=%b want=1000", {bus.req_read_dn, bus.req_write_dn}); end
    checks++; if (bus.req_rdata !== 32'h1234) begin failures++; $display("FAIL stray_rdata got=%h want=1234", bus.req_rdata); end
    clear_reqs();
    step();
  endtask

  task automatic test_reset_mid();
    bit ok;
    int cyc;
    set_req(0, 1'b1, 1'b0, 32'h40, 32'h0);
    wait_strobe(ok, cyc);
    step();
    checks++; if (bus.busy !== 1'b1) begin failures++; $display("FAIL midrst_pre_busy got=%b want=1", bus.busy); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({bus.busy, bus.mem_read_q, bus.grant_idx} !== 3'b000) begin failures++; $display("FAIL midrst_async got=%b want=000", {bus.busy, bus.mem_read_q, bus.grant_idx}); end
    checks++; if (bus.mem_addr !== 32'h0) begin failures++; $display("FAIL midrst_addr got=%h want=0", bus.mem_addr); end
    clear_reqs();
    step();
    step();
    rst_n = 1'b1;
    bus.mem_read_dn = 1'b1;
    bus.mem_rdata   = 32'hBAD0BAD0;
    step();
    bus.mem_read_dn = 1'b0;
    step();
    checks++; if ({bus.req_read_dn, bus.busy} !== 3'b000) begin failures++; $display("FAIL midrst_no_dn got=%b want=000", {bus.req_read_dn, bus.busy}); end
    set_req(0, 1'b1, 1'b0, 32'h44, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'h50, 32'h0);
    wait_strobe(ok, cyc);
    checks++; if (bus.grant_idx !== 1'b0) begin failures++; $display("FAIL midrst_priority got=%0d want=0", bus.grant_idx); end
    checks++; if (bus.mem_addr !== 32'h44) begin failures++; $display("FAIL midrst_addr2 got=%h want=44", bus.mem_addr); end
    step();
    finish_txn(1'b1, 32'h77);
    checks++; if (bus.req_read_dn !== 2'b01) begin failures++; $display("FAIL midrst_dn got=%b want=01", bus.req_read_dn); end
    clear_reqs();
    step();
  endtask

  task automatic test_watchdog();
    bit ok;
    int cyc;
    int n;
    set_req(0, 1'b1, 1'b0, 32'h60, 32'h0);
    wait_strobe(ok, cyc);
    checks++; if (bus.grant_idx !== 1'b0) begin failures++; $display("FAIL wd_grant0 got=%0d want=0", bus.grant_idx); end
    step();
`ifdef MEM_ARB_TIMEOUT_EN
    set_req(1, 1'b1, 1'b0, 32'h64, 32'h0);
    n = 0;
    while (bus.err !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checks++; if (n !== TO) begin failures++; $display("FAIL wd_err_delay got=%0d want=%0d", n, TO); end
    checks++; if ({bus.busy, bus.req_read_dn} !== 3'b000) begin failures++; $display("FAIL wd_abandon got=%b want=000", {bus.busy, bus.req_read_dn}); end
    step();
    checks++; if ({bus.err, bus.mem_read_q, bus.grant_idx} !== 3'b011) begin failures++; $display("FAIL wd_next_grant got=%b want=011", {bus.err, bus.mem_read_q, bus.grant_idx}); end
    checks++; if (bus.mem_addr !== 32'h64) begin failures++; $display("FAIL wd_next_addr got=%h want=64", bus.mem_addr); end
    step();
    clear_reqs();
    finish_txn(1'b1, 32'h99);
    checks++; if (bus.req_read_dn !== 2'b10) begin failures++; $display("FAIL wd_next_dn got=%b want=10", bus.req_read_dn); end
`else
    n = 0;
    repeat (20) begin
      step();
      n++;
    end
    checks++; if ({bus.busy, bus.err, bus.req_read_dn} !== 4'b1000) begin failures++; $display("FAIL wd_waits_forever after=%0d got=%b want=1000", n, {bus.busy, bus.err, bus.req_read_dn}); end
    finish_txn(1'b1, 32'h99);
    checks++; if (bus.req_read_dn !== 2'b01) begin failures++; $display("FAIL wd_late_dn got=%b want=01", bus.req_read_dn); end
`endif
    clear_reqs();
    step();
  endtask

  initial begin
    rst_n            = 1'b0;
    bus.mem_rdata    = '0;
    bus.mem_read_dn  = 1'b0;
    bus.mem_write_dn = 1'b0;
    mem_word         = '0;
    clear_reqs();
    test_reset();
    test_single_read();
    test_alternation();
    test_rw_same();
    test_stray_done();
    test_reset_mid();
    test_watchdog();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit reached got=running want=finished");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Round-robin arbiter sharing the single external memory controller port (read_q/write_q → read_dn/write_dn handshake) between CPU_QUANTITY requesters, typically the Cpu instances or the dispatcher.
- Serialises one transaction at a time and routes the returned data and done pulse back to the owning requester.
- Sits between the requesters and the memory controller in Top.

Parameters:
- CPU_QUANTITY, 2, number of requesters (≥2).
- ADDR_W, 32, address width (matches `ADDR_SIZE).
- DATA_W, 32, data width (matches `DATA_SIZE).
- TIMEOUT_CYCLES, 64, watchdog limit; used only with the optional feature.

Ports:
- CLK  in  1  single clock; all state on posedge.
- RESET  in  1  asynchronous, active-low reset.
- req_read_q  in  CPU_QUANTITY  per-requester read request, level.
- req_write_q  in  CPU_QUANTITY  per-requester write request, level.
- req_addr  in  CPU_QUANTITY*ADDR_W  packed addresses; requester i uses slice i.
- req_wdata  in  CPU_QUANTITY*DATA_W  packed write data.
- req_read_dn  out  CPU_QUANTITY  one-cycle read-done pulse to the owner.
- req_write_dn  out  CPU_QUANTITY  one-cycle write-done pulse to the owner.
- req_rdata  out  DATA_W  read data, valid while any req_read_dn bit is high.
- grant_idx  out  $clog2(CPU_QUANTITY)  current or last owner.
- busy  out  1  high whenever state != IDLE.
- mem_read_q  out  1  read strobe to the memory controller.
- mem_write_q  out  1  write strobe to the memory controller.
- mem_addr  out  ADDR_W  latched address.
- mem_wdata  out  DATA_W  latched write data.
- mem_rdata  in  DATA_W  controller read data.
- mem_read_dn  in  1  controller read done.
- mem_write_dn  in  1  controller write done.
- err  out  1  timeout pulse (optional feature only; tied 0 otherwise).

Behaviour:
- Reset (RESET=0, asynchronous):
  - state=IDLE; all outputs 0.
  - last_grant=CPU_QUANTITY-1, so requester 0 has first priority.
  - Reset mid-transaction abandons it; no dn is ever delivered for it.
- States: IDLE, ISSUE, WAIT_DN, RESP.
- IDLE:
  - Scan i = last_grant+1 … last_grant+CPU_QUANTITY (mod CPU_QUANTITY).
  - Pick the first i with req_read_q[i] | req_write_q[i].
  - If both are set for the same i, write is served first; the read is served in a later round.
  - Latch idx, op, addr slice and wdata slice; grant_idx=idx; go to ISSUE.
  - No request: stay in IDLE.
- ISSUE:
  - mem_read_q or mem_write_q high for exactly this one cycle, with mem_addr/mem_wdata stable.
  - Go to WAIT_DN.
- WAIT_DN:
  - mem_addr/mem_wdata are held.
  - Done matching op: capture mem_rdata (read), go to RESP.
  - Non-matching done (e.g. mem_write_dn during a read) is ignored.
- RESP:
  - req_read_dn[idx] or req_write_dn[idx] high for one cycle; req_rdata holds the captured data.
  - last_grant=idx; go to IDLE.
  - Requests are not sampled in RESP.
- Requester rules:
  - Holds its q level and addr/wdata until its dn pulse.
  - Deasserts q at the edge where it samples dn.
- Latency: request high at IDLE edge k → mem_*_q during cycle k+1 → requester dn one cycle after the controller's dn is sampled. Minimum total with the 2-cycle Top controller is 5 cycles.
- Fairness: a requester that holds its request continuously waits at most CPU_QUANTITY-1 transactions.
- Requests that drop before grant are simply not served; no state is kept.

Optional Feature:
- Macro: MEM_ARB_TIMEOUT_EN.
- When defined:
  - WAIT_DN counts cycles. Reaching TIMEOUT_CYCLES with no matching done → err pulses 1 cycle, the owner gets no dn, last_grant=idx, state goes to IDLE.
  - A late dn arriving in IDLE is ignored.
- When undefined:
  - No counter; WAIT_DN waits indefinitely; err tied 0.

Decomposition:
- Shared package/include (alongside sizes.v):
  - state encodings ARB_IDLE/ARB_ISSUE/ARB_WAIT_DN/ARB_RESP;
  - op encodings ARB_OP_READ/ARB_OP_WRITE.
- One natural sub-module: rr_pick. Combinational rotate-priority encoder; inputs req vector and last_grant, outputs found and index. It is reused by the dispatcher's CPU loop.

Test Plan:
- Reset then single read: req_read_q[1]=1, addr=0x10, model mem[0x10]=0xDEADBEEF → mem_read_q one cycle with mem_addr=0x10; req_read_dn[1] pulses with req_rdata=0xDEADBEEF; req_read_dn[0] stays 0; grant_idx=1.
- Simultaneous requests after reset: both requesters hold read → requester 0 served first, then 1; next round with both still requesting serves 0 again (alternation verified over 6 transactions).
- Same-requester read+write: req0 write 0x5 to 0x20 and read 0x20 both high → write_dn first, then read returns 0x5.
- Stray done: during a read, inject mem_write_dn → ignored; only mem_read_dn completes; no spurious req_write_dn.
- Reset mid-WAIT_DN: assert RESET=0 → all outputs 0 immediately (asynchronous); after release, no dn for the aborted transaction; requester 0 has priority.
- MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, controller never responds → err pulse 8 cycles after entering WAIT_DN; busy drops; other requester then granted.
